// File: rtl/axi_arb_pkg.sv
// Shared types for the N-port AXI-lite arbiter: FSM state encoding and the
// grant-index width helper used by the top and the round-robin picker.
package axi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } arb_state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axi_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo N_MST.
module axi_rr_pick
   import axi_arb_pkg::*;
#(
   parameter  int N_MST = 2,
   localparam int IDX_W = idx_w(N_MST)
) (
   input  logic [N_MST-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_MST-1:0] onehot_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             found_o
);

   // Scan from the far end so the candidate closest to ptr_i is written last.
   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      found_o  = 1'b0;
      for (int k = N_MST - 1; k >= 0; k--) begin
         if (req_i[(int'(ptr_i) + k) % N_MST]) begin
            idx_o   = IDX_W'((int'(ptr_i) + k) % N_MST);
            found_o = 1'b1;
         end
      end
      if (found_o) onehot_o[idx_o] = 1'b1;
   end

endmodule

// File: rtl/axi_arbiter_nport.sv
// N-master to 1-slave single-beat AXI-lite arbiter, one transaction in flight.
// Optional high-priority master enabled by defining AXI_ARB_HIPRI_EN.
//
// state | meaning
// IDLE  | no owner; arbitrate among AW/AR requesters
// WR    | granted master's AW/W routed to slave, waiting for B handshake
// RD    | granted master's AR routed to slave, waiting for R handshake
module axi_arbiter_nport
   import axi_arb_pkg::*;
#(
   parameter  int N_MST     = 2,
   parameter  int ADDR_W    = 64,
   parameter  int DATA_W    = 64,
   parameter  int HIPRI_IDX = 1,
   localparam int STRB_W    = DATA_W / 8,
   localparam int IDX_W     = idx_w(N_MST)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_MST-1:0][ADDR_W-1:0]  m_aw_addr,
   input  logic [N_MST-1:0]              m_aw_valid,
   output logic [N_MST-1:0]              m_aw_ready,
   input  logic [N_MST-1:0][DATA_W-1:0]  m_w_data,
   input  logic [N_MST-1:0][STRB_W-1:0]  m_w_strb,
   input  logic [N_MST-1:0]              m_w_valid,
   output logic [N_MST-1:0]              m_w_ready,
   output logic [N_MST-1:0]              m_b_valid,
   input  logic [N_MST-1:0]              m_b_ready,
   input  logic [N_MST-1:0][ADDR_W-1:0]  m_ar_addr,
   input  logic [N_MST-1:0]              m_ar_valid,
   output logic [N_MST-1:0]              m_ar_ready,
   output logic [DATA_W-1:0]             m_r_data,
   output logic [N_MST-1:0]              m_r_valid,
   input  logic [N_MST-1:0]              m_r_ready,
   output logic [ADDR_W-1:0]             s_aw_addr,
   output logic                          s_aw_valid,
   input  logic                          s_aw_ready,
   output logic [DATA_W-1:0]             s_w_data,
   output logic [STRB_W-1:0]             s_w_strb,
   output logic                          s_w_valid,
   input  logic                          s_w_ready,
   input  logic                          s_b_valid,
   output logic                          s_b_ready,
   output logic [ADDR_W-1:0]             s_ar_addr,
   output logic                          s_ar_valid,
   input  logic                          s_ar_ready,
   input  logic [DATA_W-1:0]             s_r_data,
   input  logic                          s_r_valid,
   output logic                          s_r_ready,
   output logic [IDX_W-1:0]              grant_idx,
   output logic                          busy
);

`ifdef AXI_ARB_HIPRI_EN
   localparam bit HIPRI_EN = 1'b1;
`else
   localparam bit HIPRI_EN = 1'b0;
`endif

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

   logic [N_MST-1:0] req;
   logic [N_MST-1:0] pick_onehot;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_found;
   logic [IDX_W-1:0] win_idx;
   logic             win_aw;
   logic [IDX_W-1:0] ptr_nxt;
   logic             ptr_adv;

   assign req = m_aw_valid | m_ar_valid;

   axi_rr_pick #(.N_MST(N_MST)) u_pick (
      .req_i    (req),
      .ptr_i    (rr_ptr_q),
      .onehot_o (pick_onehot),
      .idx_o    (pick_idx),
      .found_o  (pick_found)
   );

   assign ptr_nxt = (grant_q == IDX_W'(N_MST - 1)) ? '0 : grant_q + 1'b1;
   // The priority master does not move the pointer, so the others keep their rotation.
   assign ptr_adv = !(HIPRI_EN && (grant_q == IDX_W'(HIPRI_IDX)));

   always_comb begin
      if (HIPRI_EN && req[HIPRI_IDX]) begin
         win_idx = IDX_W'(HIPRI_IDX);
         win_aw  = m_aw_valid[HIPRI_IDX];
      end else begin
         win_idx = pick_idx;
         win_aw  = |(pick_onehot & m_aw_valid);
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      m_aw_ready = '0;
      m_w_ready  = '0;
      m_b_valid  = '0;
      m_ar_ready = '0;
      m_r_valid  = '0;
      s_aw_valid = 1'b0;
      s_w_valid  = 1'b0;
      s_b_ready  = 1'b0;
      s_ar_valid = 1'b0;
      s_r_ready  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d = win_idx;
               state_d = win_aw ? WR : RD;
            end
         end
         WR: begin
            s_aw_valid          = m_aw_valid[grant_q];
            s_w_valid           = m_w_valid[grant_q];
            s_b_ready           = m_b_ready[grant_q];
            m_aw_ready[grant_q] = s_aw_ready;
            m_w_ready[grant_q]  = s_w_ready;
            m_b_valid[grant_q]  = s_b_valid;
            if (s_b_valid && m_b_ready[grant_q]) begin
               state_d = IDLE;
               if (ptr_adv) rr_ptr_d = ptr_nxt;
            end
         end
         RD: begin
            s_ar_valid          = m_ar_valid[grant_q];
            s_r_ready           = m_r_ready[grant_q];
            m_ar_ready[grant_q] = s_ar_ready;
            m_r_valid[grant_q]  = s_r_valid;
            if (s_r_valid && m_r_ready[grant_q]) begin
               state_d = IDLE;
               if (ptr_adv) rr_ptr_d = ptr_nxt;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign s_aw_addr = m_aw_addr[grant_q];
   assign s_w_data  = m_w_data[grant_q];
   assign s_w_strb  = m_w_strb[grant_q];
   assign s_ar_addr = m_ar_addr[grant_q];
   assign m_r_data  = s_r_data;
   assign grant_idx = grant_q;
   assign busy      = (state_q != IDLE);

endmodule
